spi_ram_ctrl: RTL and testbench

//  Parametrised command-decoded RAM behind the SPI slave.
//  - Accepts {cmd[1:0], payload} words from the SPI receive path.
//  - Returns read data to the SPI transmit path over a valid/ready handshake.
//  - Adds over the previous generation: configurable width and depth, address

---
 rtl/spi_ram_ctrl_if.sv | 26 ++
 rtl/spi_ram_ctrl.sv | 114 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// Command/response channel between the SPI slave datapath and the RAM controller.
// The master drives commands and accepts read data; the slave is the controller.
interface spi_ram_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    localparam int P_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    logic [P_W+1:0]    din;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;

    modport master (
        output din, rx_valid, tx_ready,
        input  rx_ready, dout, tx_valid, err
    );

    modport slave (
        input  din, rx_valid, tx_ready,
        output rx_ready, dout, tx_valid, err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM behind the SPI slave: set/write/read with optional address
// auto-increment, read data returned over a valid/ready handshake, sticky range error.
module spi_ram_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2 ** ADDR_W,
    parameter int AUTO_INC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_ctrl_if.slave  bus
);
    localparam int P_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_SET_WA = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_SET_RA = 2'b10,
        CMD_READ   = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] dout_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    cmd_e              cmd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              tx_valid;
    logic              accept;
    logic              read_accept;

    assign cmd         = cmd_e'(bus.din[P_W+1:P_W]);
    assign cmd_addr    = bus.din[ADDR_W-1:0];
    assign cmd_data    = bus.din[DATA_W-1:0];
    assign tx_valid    = (state == HOLD);
    assign accept      = bus.rx_valid && bus.rx_ready;
    assign read_accept = accept && (cmd == CMD_READ);

    // A pending word blocks new commands unless it is being taken this cycle.
    assign bus.rx_ready = ~tx_valid | bus.tx_ready;
    assign bus.tx_valid = tx_valid;
    assign bus.dout     = dout_q;
    assign bus.err      = err_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    // Out-of-range addresses (reachable only via SET_*) simply count up and roll over.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0) return a;
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // NOTE: next-state logic assigns its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (read_accept) state_nxt = HOLD;
            HOLD: if (bus.tx_ready && !read_accept) state_nxt = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            unique case (cmd)
                CMD_SET_WA: begin
                    wr_addr <= cmd_addr;
                    if (!in_range(cmd_addr)) err_q <= 1'b1;
                end
                CMD_WRITE: begin
                    if (!in_range(wr_addr)) err_q <= 1'b1;
                    wr_addr <= next_addr(wr_addr);
                end
                CMD_SET_RA: begin
                    rd_addr <= cmd_addr;
                    if (!in_range(cmd_addr)) err_q <= 1'b1;
                end
                CMD_READ: begin
                    dout_q  <= in_range(rd_addr) ? mem[rd_addr] : '0;
                    if (!in_range(rd_addr)) err_q <= 1'b1;
                    rd_addr <= next_addr(rd_addr);
                end
            endcase
        end
    end

    // NOTE: the array has no reset so its contents survive rst_n and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && cmd == CMD_WRITE && in_range(wr_addr))
            mem[wr_addr] <= cmd_data;
    end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three instances (full depth, DEPTH=200, AUTO_INC=0) share stimulus;
// each is compared against an array-based command model, plus directed constant checks.
module tb_spi_ram_ctrl;
    localparam logic [1:0] SET_WA = 2'b00, WRITE = 2'b01, SET_RA = 2'b10, READ = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    spi_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    spi_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

    spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8))              u_dut_full  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) u_dut_d200  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) u_dut_noinc (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.din = din; assign bus0.rx_valid = rx_valid; assign bus0.tx_ready = tx_ready;
    assign bus1.din = din; assign bus1.rx_valid = rx_valid; assign bus1.tx_ready = tx_ready;
    assign bus2.din = din; assign bus2.rx_valid = rx_valid; assign bus2.tx_ready = tx_ready;

    logic       obs_rxr  [3];
    logic       obs_txv  [3];
    logic       obs_err  [3];
    logic [7:0] obs_dout [3];
    assign obs_rxr[0] = bus0.rx_ready; assign obs_txv[0] = bus0.tx_valid;
    assign obs_err[0] = bus0.err;      assign obs_dout[0] = bus0.dout;
    assign obs_rxr[1] = bus1.rx_ready; assign obs_txv[1] = bus1.tx_valid;
    assign obs_err[1] = bus1.err;      assign obs_dout[1] = bus1.dout;
    assign obs_rxr[2] = bus2.rx_ready; assign obs_txv[2] = bus2.tx_valid;
    assign obs_err[2] = bus2.err;      assign obs_dout[2] = bus2.dout;

    // Reference model: one entry per instance
    int unsigned m_depth [3] = '{256, 200, 256};
    bit          m_ainc  [3] = '{1'b1, 1'b1, 1'b0};
    int unsigned m_wa [3];
    int unsigned m_ra [3];
    logic [7:0]  m_dout [3];
    bit          m_dknown [3];
    bit          m_txv [3];
    bit          m_err [3];
    logic [7:0]  m_mem [3][256];
    bit          m_known [3][256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         v;
        logic [1:0] cmd;
        logic [7:0] pay;
        bit         txr;
        bit         exp_txv;
        logic [7:0] exp_dout;
        bit         exp_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit v, logic [1:0] c, logic [7:0] p, bit tr,
                                bit etxv, logic [7:0] edout, bit eerr);
        vec_t r;
        r.v = v; r.cmd = c; r.pay = p; r.txr = tr;
        r.exp_txv = etxv; r.exp_dout = edout; r.exp_err = eerr;
        return r;
    endfunction

    function automatic logic [7:0] init_val(int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic int unsigned bump(int k, int unsigned a);
        if (!m_ainc[k]) return a;
        return (a == m_depth[k] - 1) ? 0 : (a + 1) % 256;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wa[k] = 0; m_ra[k] = 0; m_dout[k] = 8'h00; m_dknown[k] = 1'b1;
            m_txv[k] = 1'b0; m_err[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(int k, bit v, logic [1:0] c, logic [7:0] p, bit tr);
        bit acc = v && (!m_txv[k] || tr);
        bit rd  = acc && (c == READ);
        if (acc) begin
            case (c)
                SET_WA: begin m_wa[k] = p; if (p >= m_depth[k]) m_err[k] = 1'b1; end
                WRITE: begin
                    if (m_wa[k] < m_depth[k]) begin
                        m_mem[k][m_wa[k]] = p; m_known[k][m_wa[k]] = 1'b1;
                    end else m_err[k] = 1'b1;
                    m_wa[k] = bump(k, m_wa[k]);
                end
                SET_RA: begin m_ra[k] = p; if (p >= m_depth[k]) m_err[k] = 1'b1; end
                default: begin
                    if (m_ra[k] < m_depth[k]) begin
                        m_dout[k] = m_mem[k][m_ra[k]]; m_dknown[k] = m_known[k][m_ra[k]];
                    end else begin
                        m_dout[k] = 8'h00; m_dknown[k] = 1'b1; m_err[k] = 1'b1;
                    end
                    m_ra[k] = bump(k, m_ra[k]);
                end
            endcase
        end
        if (rd) m_txv[k] = 1'b1;
        else if (tr) m_txv[k] = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("tx_valid[%0d]", k), obs_txv[k], m_txv[k]);
            check($sformatf("err[%0d]", k), obs_err[k], m_err[k]);
            if (m_dknown[k]) check($sformatf("dout[%0d]", k), obs_dout[k], m_dout[k]);
        end
    endtask

    // One clock: drive at negedge, check rx_ready, step model at the edge, check outputs after it.
    task automatic cyc(input bit v, input logic [1:0] c, input logic [7:0] p, input bit tr);
        @(negedge clk);
        rx_valid = v; din = {c, p}; tx_ready = tr;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("rx_ready[%0d]", k), obs_rxr[k], !m_txv[k] || tr);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, v, c, p, tr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] held;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 256; a++) m_known[k][a] = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Basic write/read, then burst across the top of a 256-word space
        vq.push_back(mk(1, SET_WA, 8'h10, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, WRITE,  8'hA5, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, SET_RA, 8'h10, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, READ,   8'h00, 1, 1, 8'hA5, 0));
        vq.push_back(mk(0, SET_WA, 8'h00, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, SET_WA, 8'hFE, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, WRITE,  8'h11, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, WRITE,  8'h22, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, WRITE,  8'h33, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, SET_RA, 8'hFE, 1, 0, 8'hA5, 0));
        vq.push_back(mk(1, READ,   8'h00, 1, 1, 8'h11, 0));
        vq.push_back(mk(1, READ,   8'h00, 1, 1, 8'h22, 0));
        vq.push_back(mk(1, READ,   8'h00, 1, 1, 8'h33, 0));
        vq.push_back(mk(1, SET_RA, 8'h00, 1, 0, 8'h33, 0));
        vq.push_back(mk(1, READ,   8'h00, 1, 1, 8'h33, 0));
        vq.push_back(mk(0, SET_WA, 8'h00, 1, 0, 8'h33, 0));
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].v, vq[i].cmd, vq[i].pay, vq[i].txr);
            check($sformatf("vec%0d tx_valid", i), obs_txv[0], vq[i].exp_txv);
            check($sformatf("vec%0d dout", i), obs_dout[0], vq[i].exp_dout);
            check($sformatf("vec%0d err", i), obs_err[0], vq[i].exp_err);
        end

        // Fill words 0..199 in every instance with known data
        for (int a = 0; a < 200; a++) begin
            cyc(1, SET_WA, 8'(a), 1);
            cyc(1, WRITE, init_val(a), 1);
        end

        // Backpressure: pending word blocks a held WRITE until tx_ready
        cyc(1, SET_WA, 8'h20, 1);
        cyc(1, SET_RA, 8'h20, 1);
        cyc(1, READ, 8'h00, 0);
        check("bp first dout", obs_dout[0], init_val(32));
        held = init_val(32);
        for (int i = 0; i < 4; i++) begin
            cyc(1, WRITE, 8'h5A, 0);
            check("bp rx_ready low", obs_rxr[0], 1'b0);
            check("bp dout stable", obs_dout[0], held);
        end
        cyc(1, WRITE, 8'h5A, 1);
        check("bp released", obs_txv[0], 1'b0);
        cyc(1, SET_RA, 8'h20, 1);
        cyc(1, READ, 8'h00, 1);
        check("bp write landed", obs_dout[0], 8'h5A);

        // AUTO_INC=0 instance keeps the address on repeated writes/reads
        cyc(1, SET_WA, 8'h05, 1);
        cyc(1, WRITE, 8'h77, 1);
        cyc(1, WRITE, 8'h88, 1);
        cyc(1, SET_RA, 8'h05, 1);
        cyc(1, READ, 8'h00, 1);
        check("noinc second write", obs_dout[2], 8'h88);
        check("inc first write", obs_dout[0], 8'h77);
        cyc(1, READ, 8'h00, 1);
        check("noinc reread", obs_dout[2], 8'h88);
        check("inc next word", obs_dout[0], 8'h88);
        cyc(1, SET_RA, 8'h06, 1);
        cyc(1, READ, 8'h00, 1);
        check("noinc neighbour untouched", obs_dout[2], init_val(6));

        // DEPTH=200 instance: out-of-range set/write/read
        do_reset();
        cyc(1, SET_WA, 8'hC8, 1);
        check("d200 err on SET_WA", obs_err[1], 1'b1);
        check("full no err", obs_err[0], 1'b0);
        cyc(1, WRITE, 8'h55, 1);
        cyc(1, SET_RA, 8'hC8, 1);
        cyc(1, READ, 8'h00, 1);
        check("d200 oob dout", obs_dout[1], 8'h00);
        check("d200 oob tx_valid", obs_txv[1], 1'b1);
        check("full C8 dout", obs_dout[0], 8'h55);
        cyc(1, SET_RA, 8'hC7, 1);
        cyc(1, READ, 8'h00, 1);
        check("d200 top word intact", obs_dout[1], init_val(199));
        check("d200 err sticky", obs_err[1], 1'b1);

        // Reset while a word is pending; memory must survive
        cyc(1, READ, 8'h00, 0);
        check("pre-reset tx_valid", obs_txv[0], 1'b1);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async tx_valid[%0d]", k), obs_txv[k], 1'b0);
            check($sformatf("async err[%0d]", k), obs_err[k], 1'b0);
            check($sformatf("async dout[%0d]", k), obs_dout[k], 8'h00);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, SET_RA, 8'h40, 1);
        cyc(1, READ, 8'h00, 1);
        check("mem survives reset", obs_dout[0], init_val(64));

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bit         v  = ($urandom_range(0, 4) != 0);
            logic [1:0] c  = 2'($urandom_range(0, 3));
            logic [7:0] p  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 199));
            bit         tr = ($urandom_range(0, 2) != 0);
            cyc(v, c, p, tr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
